// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous memory between the
// fetch stage (read-only) and the MEM stage (load/store). Every access runs
// IDLE -> ISSUE -> RESP and produces exactly one ack pulse. Data has priority,
// bounded by a streak counter so a waiting fetch cannot starve.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  // pipeline stalls
  output logic              stall_fetch,
  output logic              stall_data,
  // memory port
  output logic              m_en,
  output logic              m_we,
  output logic [2:0]        m_funct3,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int unsigned           STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [2:0]            F3_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_I,
    S_ISSUE_D,
    S_RESP_I,
    S_RESP_D
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // access descriptor captured at the grant edge
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic                mis_q, mis_d;

  logic [31:0]         if_rdata_q, d_rdata_q;

  logic                d_misaligned;
  logic                d_wins;
  logic                d_load_done;

  // Fetch addresses are word aligned; the two low bits are intentionally dropped.
  logic                unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  // Misalignment of the incoming data request (halfword on odd byte, word off a 4-byte boundary).
  always_comb begin
    d_misaligned = 1'b0;
    case (d_funct3[1:0])
      2'b01:   d_misaligned = d_addr[0];
      2'b10:   d_misaligned = (d_addr[1:0] != 2'b00);
      default: d_misaligned = 1'b0;
    endcase
  end

  // Data wins arbitration unless a fetch is waiting and the data streak is exhausted.
  assign d_wins = d_req & (~if_req | (streak_q < STREAK_MAX));

  // State, streak counter and latched access descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      mis_q    <= mis_d;
    end
  end

  // Next-state logic: arbitration in IDLE, fixed ISSUE -> RESP -> IDLE walk otherwise.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    f3_d     = f3_q;
    mis_d    = mis_q;
    case (state_q)
      S_IDLE: begin
        if (d_wins) begin
          state_d = S_ISSUE_D;
          if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
          f3_d    = d_funct3;
          mis_d   = d_misaligned;
        end else if (if_req) begin
          state_d  = S_ISSUE_I;
          streak_d = '0;
          addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = '0;
          we_d     = 1'b0;
          f3_d     = F3_WORD;
          mis_d    = 1'b0;
        end else begin
          streak_d = '0;
        end
      end
      S_ISSUE_I: state_d = S_RESP_I;
      S_ISSUE_D: state_d = S_RESP_D;
      S_RESP_I:  state_d = S_IDLE;
      S_RESP_D:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Memory port: enable only in ISSUE states; a misaligned data access is never issued.
  always_comb begin
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = addr_q;
    m_wdata  = wdata_q;
    m_funct3 = f3_q;
    case (state_q)
      S_ISSUE_I: m_en = 1'b1;
      S_ISSUE_D: begin
        m_en = ~mis_q;
        m_we = ~mis_q & we_q;
      end
      default: begin
        m_en = 1'b0;
        m_we = 1'b0;
      end
    endcase
  end

  // Acks and error flag are decoded from the response states.
  always_comb begin
    if_ack = (state_q == S_RESP_I);
    d_ack  = (state_q == S_RESP_D);
    d_err  = (state_q == S_RESP_D) & mis_q;
  end

  assign d_load_done = d_ack & ~we_q & ~mis_q;

  // Read data is forwarded from memory in the ack cycle, then held until the next ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_ack) begin
        if_rdata_q <= m_rdata;
      end
      if (d_load_done) begin
        d_rdata_q <= m_rdata;
      end
    end
  end

  // Read data outputs and combinational stalls (released in the ack cycle).
  always_comb begin
    if_rdata    = if_ack ? m_rdata : if_rdata_q;
    d_rdata     = d_load_done ? m_rdata : d_rdata_q;
    stall_fetch = if_req & ~if_ack;
    stall_data  = d_req & ~d_ack;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: per-cycle vector table for single accesses,
// plus hand sequences for sustained contention and reset during an access.
module tb_unified_mem_arbiter;

  localparam logic [2:0]  F_B = 3'b000;
  localparam logic [2:0]  F_H = 3'b001;
  localparam logic [2:0]  F_W = 3'b010;
  localparam logic [31:0] WA  = 32'h0F0E0D0C;  // word at 0x0C
  localparam logic [31:0] WB  = 32'hDEADBEEF;  // stored to 0x10
  localparam logic [31:0] WC  = 32'h23222120;  // word at 0x20
  localparam logic [31:0] WD  = 32'h2322AB20;  // word at 0x20 after SB 0x21

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        stall_fetch;
  logic        stall_data;
  logic        m_en;
  logic        m_we;
  logic [2:0]  m_funct3;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  unified_mem_arbiter #(.ADDR_W(8), .MAX_D_STREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_funct3   (d_funct3),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .stall_fetch(stall_fetch),
    .stall_data (stall_data),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_funct3   (m_funct3),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory model: mem[i] = i after reset; reads return the aligned word a cycle later.
  logic [7:0] mem [256];
  logic [7:0] wa;
  always @(posedge clk) begin
    wa = {m_addr[7:2], 2'b00};
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (m_en) begin
      if (m_we) begin
        case (m_funct3[1:0])
          2'b00: mem[m_addr] <= m_wdata[7:0];
          2'b01: begin
            mem[m_addr]        <= m_wdata[7:0];
            mem[m_addr + 8'd1] <= m_wdata[15:8];
          end
          default: begin
            mem[wa]        <= m_wdata[7:0];
            mem[wa + 8'd1] <= m_wdata[15:8];
            mem[wa + 8'd2] <= m_wdata[23:16];
            mem[wa + 8'd3] <= m_wdata[31:24];
          end
        endcase
      end else begin
        m_rdata <= {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};
      end
    end
  end

  typedef struct {
    logic        ireq;
    logic [7:0]  iaddr;
    logic        dreq;
    logic        dwe;
    logic [2:0]  df3;
    logic [7:0]  daddr;
    logic [31:0] dwdata;
    logic        iack;
    logic        dack;
    logic        derr;
    logic        men;
    logic        mwe;
    logic        chka;
    logic [7:0]  maddr;
    logic [2:0]  mf3;
    logic        sf;
    logic        sd;
    logic [31:0] ir;
    logic [31:0] dr;
  } vec_t;

  function automatic vec_t mk(
    input logic ireq, input logic [7:0] iaddr,
    input logic dreq, input logic dwe, input logic [2:0] df3,
    input logic [7:0] daddr, input logic [31:0] dwdata,
    input logic iack, input logic dack, input logic derr,
    input logic men, input logic mwe, input logic chka,
    input logic [7:0] maddr, input logic [2:0] mf3,
    input logic sf, input logic sd, input logic [31:0] ir, input logic [31:0] dr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.df3 = df3;
    v.daddr = daddr; v.dwdata = dwdata; v.iack = iack; v.dack = dack; v.derr = derr;
    v.men = men; v.mwe = mwe; v.chka = chka; v.maddr = maddr; v.mf3 = mf3;
    v.sf = sf; v.sd = sd; v.ir = ir; v.dr = dr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [7:0] iaddr, input logic dreq,
                       input logic dwe, input logic [2:0] df3, input logic [7:0] daddr,
                       input logic [31:0] dwdata);
    if_req = ireq; if_addr = iaddr; d_req = dreq; d_we = dwe;
    d_funct3 = df3; d_addr = daddr; d_wdata = dwdata;
  endtask

  vec_t vt [30];
  logic exp_d [10];

  initial begin
    // ireq iaddr  dreq we f3   daddr  wdata        iack dack derr men mwe chka maddr f3   sf sd ir  dr
    vt[0]  = mk(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0,    0, 0, 0, 0, 0, 1, 8'h00, F_B, 0, 0, 32'h0, 32'h0);
    vt[1]  = mk(1, 8'h0E, 0, 0, F_B, 8'h00, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 1, 0, 32'h0, 32'h0);
    vt[2]  = mk(1, 8'h0E, 0, 0, F_B, 8'h00, 32'h0,    0, 0, 0, 1, 0, 1, 8'h0C, F_W, 1, 0, 32'h0, 32'h0);
    vt[3]  = mk(1, 8'h0E, 0, 0, F_B, 8'h00, 32'h0,    1, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    32'h0);
    vt[4]  = mk(0, 8'h00, 1, 1, F_W, 8'h10, WB,       0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    32'h0);
    vt[5]  = mk(0, 8'h00, 1, 1, F_W, 8'h10, WB,       0, 0, 0, 1, 1, 1, 8'h10, F_W, 0, 1, WA,    32'h0);
    vt[6]  = mk(0, 8'h00, 1, 1, F_W, 8'h10, WB,       0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    32'h0);
    vt[7]  = mk(0, 8'h00, 1, 0, F_W, 8'h10, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    32'h0);
    vt[8]  = mk(0, 8'h00, 1, 0, F_W, 8'h10, 32'h0,    0, 0, 0, 1, 0, 1, 8'h10, F_W, 0, 1, WA,    32'h0);
    vt[9]  = mk(0, 8'h00, 1, 0, F_W, 8'h10, 32'h0,    0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WB);
    vt[10] = mk(0, 8'h00, 1, 0, F_W, 8'h06, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WB);
    vt[11] = mk(0, 8'h00, 1, 0, F_W, 8'h06, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WB);
    vt[12] = mk(0, 8'h00, 1, 0, F_W, 8'h06, 32'h0,    0, 1, 1, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WB);
    vt[13] = mk(0, 8'h00, 1, 0, F_W, 8'h20, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WB);
    vt[14] = mk(0, 8'h00, 1, 0, F_W, 8'h24, 32'h0,    0, 0, 0, 1, 0, 1, 8'h20, F_W, 0, 1, WA,    WB);
    vt[15] = mk(0, 8'h00, 1, 0, F_W, 8'h24, 32'h0,    0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WC);
    vt[16] = mk(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WC);
    vt[17] = mk(0, 8'h00, 1, 0, F_H, 8'h11, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WC);
    vt[18] = mk(0, 8'h00, 1, 0, F_H, 8'h11, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WC);
    vt[19] = mk(0, 8'h00, 1, 0, F_H, 8'h11, 32'h0,    0, 1, 1, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WC);
    vt[20] = mk(0, 8'h00, 1, 0, F_B, 8'h13, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WC);
    vt[21] = mk(0, 8'h00, 1, 0, F_B, 8'h13, 32'h0,    0, 0, 0, 1, 0, 1, 8'h13, F_B, 0, 1, WA,    WC);
    vt[22] = mk(0, 8'h00, 1, 0, F_B, 8'h13, 32'h0,    0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WB);
    vt[23] = mk(0, 8'h00, 1, 1, F_B, 8'h21, 32'hAB,   0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WB);
    vt[24] = mk(0, 8'h00, 1, 1, F_B, 8'h21, 32'hAB,   0, 0, 0, 1, 1, 1, 8'h21, F_B, 0, 1, WA,    WB);
    vt[25] = mk(0, 8'h00, 1, 1, F_B, 8'h21, 32'hAB,   0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WB);
    vt[26] = mk(0, 8'h00, 1, 0, F_W, 8'h20, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 1, WA,    WB);
    vt[27] = mk(0, 8'h00, 1, 0, F_W, 8'h20, 32'h0,    0, 0, 0, 1, 0, 1, 8'h20, F_W, 0, 1, WA,    WB);
    vt[28] = mk(0, 8'h00, 1, 0, F_W, 8'h20, 32'h0,    0, 1, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WD);
    vt[29] = mk(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0,    0, 0, 0, 0, 0, 0, 8'h00, F_B, 0, 0, WA,    WD);

    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 1; exp_d[4] = 0;
    exp_d[5] = 1; exp_d[6] = 1; exp_d[7] = 1; exp_d[8] = 1; exp_d[9] = 0;

    rst = 1'b1;
    drive(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single accesses, one table row per cycle; inputs at negedge, outputs checked 1 time unit later.
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      drive(vt[i].ireq, vt[i].iaddr, vt[i].dreq, vt[i].dwe, vt[i].df3, vt[i].daddr, vt[i].dwdata);
      #1;
      chk($sformatf("r%0d.if_ack", i),      32'(if_ack),      32'(vt[i].iack));
      chk($sformatf("r%0d.d_ack", i),       32'(d_ack),       32'(vt[i].dack));
      chk($sformatf("r%0d.d_err", i),       32'(d_err),       32'(vt[i].derr));
      chk($sformatf("r%0d.m_en", i),        32'(m_en),        32'(vt[i].men));
      chk($sformatf("r%0d.m_we", i),        32'(m_we),        32'(vt[i].mwe));
      chk($sformatf("r%0d.stall_fetch", i), 32'(stall_fetch), 32'(vt[i].sf));
      chk($sformatf("r%0d.stall_data", i),  32'(stall_data),  32'(vt[i].sd));
      chk($sformatf("r%0d.if_rdata", i),    if_rdata,         vt[i].ir);
      chk($sformatf("r%0d.d_rdata", i),     d_rdata,          vt[i].dr);
      if (vt[i].chka) begin
        chk($sformatf("r%0d.m_addr", i),   32'(m_addr),   32'(vt[i].maddr));
        chk($sformatf("r%0d.m_funct3", i), 32'(m_funct3), 32'(vt[i].mf3));
      end
    end

    // Sustained contention: acks every 3 cycles, order D,D,D,D,I,D,D,D,D,I.
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drive(1, 8'h0C, 1, 0, F_W, 8'h20, 32'h0);
      #1;
      chk($sformatf("arb%0d.if_ack", c), 32'(if_ack), 32'((c % 3 == 2) && !exp_d[c / 3]));
      chk($sformatf("arb%0d.d_ack", c),  32'(d_ack),  32'((c % 3 == 2) &&  exp_d[c / 3]));
      if ((c % 3 == 2) && !exp_d[c / 3]) chk($sformatf("arb%0d.if_rdata", c), if_rdata, WA);
      if ((c % 3 == 2) &&  exp_d[c / 3]) chk($sformatf("arb%0d.d_rdata", c),  d_rdata,  WD);
    end

    // Reset while a fetch is in ISSUE_I: no ack afterwards, every output back to reset value.
    @(negedge clk);
    drive(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0);
    @(negedge clk);
    drive(1, 8'h0C, 0, 0, F_B, 8'h00, 32'h0);
    @(negedge clk);
    #1;
    chk("rst.pre_m_en", 32'(m_en), 32'd1);
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, F_B, 8'h00, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.if_ack",      32'(if_ack),      32'd0);
    chk("rst.d_ack",       32'(d_ack),       32'd0);
    chk("rst.d_err",       32'(d_err),       32'd0);
    chk("rst.m_en",        32'(m_en),        32'd0);
    chk("rst.m_we",        32'(m_we),        32'd0);
    chk("rst.m_addr",      32'(m_addr),      32'd0);
    chk("rst.m_funct3",    32'(m_funct3),    32'd0);
    chk("rst.m_wdata",     m_wdata,          32'd0);
    chk("rst.if_rdata",    if_rdata,         32'd0);
    chk("rst.d_rdata",     d_rdata,          32'd0);
    chk("rst.stall_fetch", 32'(stall_fetch), 32'd0);
    chk("rst.stall_data",  32'(stall_data),  32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst.quiet%0d.if_ack", c), 32'(if_ack), 32'd0);
      chk($sformatf("rst.quiet%0d.m_en", c),   32'(m_en),   32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
